// File: rtl/lab2_proc_hazard_pkg.sv
// Shared types and bypass-select encodings for the TinyRV2 hazard controller.
package lab2_proc_hazard_pkg;

    // op1 bypass mux order: rf, X, M, W
    localparam logic [1:0] BYP1_RF = 2'd0;
    localparam logic [1:0] BYP1_X  = 2'd1;
    localparam logic [1:0] BYP1_M  = 2'd2;
    localparam logic [1:0] BYP1_W  = 2'd3;

    // op2 bypass mux order differs in the datapath: X, M, W, rf
    localparam logic [1:0] BYP2_X  = 2'd0;
    localparam logic [1:0] BYP2_M  = 2'd1;
    localparam logic [1:0] BYP2_W  = 2'd2;
    localparam logic [1:0] BYP2_RF = 2'd3;

    typedef struct packed {
        logic       val;
        logic       wen;
        logic [4:0] rd;
        logic       is_load;
        logic       is_mul;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

    // A stage can forward to source rs when it holds a valid register write to rs.
    function automatic logic byp_match(input stage_info_t s, input logic [4:0] rs);
        return s.val & s.wen & (s.rd == rs);
    endfunction

endpackage

// File: rtl/lab2_proc_hazard_stage_reg.sv
// One pipeline stage's control record: hold when stalled, else load a bubble or the upstream entry.
module lab2_proc_hazard_stage_reg
    import lab2_proc_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    // Stage register; reset drops the entry immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= STAGE_BUBBLE;
        end else if (!hold) begin
            q <= bubble ? STAGE_BUBBLE : d;
        end
    end

endmodule

// File: rtl/lab2_proc_hazard_ctrl.sv
// Stall/bypass scheduler for the 5-stage TinyRV2 pipeline with the iterative multiplier.
module lab2_proc_hazard_ctrl
    import lab2_proc_hazard_pkg::*;
#(
    parameter int unsigned p_cnt_nbits = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   val_D,
    input  logic                   squash_D,
    input  logic                   rs1_en_D,
    input  logic                   rs2_en_D,
    input  logic [4:0]             rs1_D,
    input  logic [4:0]             rs2_D,
    input  logic                   rf_wen_D,
    input  logic [4:0]             rd_D,
    input  logic                   is_load_D,
    input  logic                   is_mul_D,
    input  logic                   stall_X_ext,
    input  logic                   stall_M_ext,
    input  logic                   stall_W_ext,
    input  logic                   imul_req_rdy,
    input  logic                   imul_resp_val,
    input  logic                   stats_en,
    output logic [1:0]             op1_byp_sel_D,
    output logic [1:0]             op2_byp_sel_D,
    output logic                   stall_D,
    output logic                   stall_X,
    output logic                   stall_M,
    output logic                   stall_W,
    output logic                   imul_req_val,
    output logic                   imul_resp_rdy,
    output logic                   val_X,
    output logic                   val_M,
    output logic                   val_W,
    output logic [p_cnt_nbits-1:0] stall_cycles
);

    stage_info_t x_q, m_q, w_q;
    stage_info_t x_d;
    logic        luse;
    logic        stall_D_nm;
    logic        x_bubble;
    logic [p_cnt_nbits-1:0] stall_cycles_q;

    // M/W only forward; their load/mul flags are carried along but never consulted.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{m_q.is_load, m_q.is_mul, w_q.is_load, w_q.is_mul};

    // Stall chain from W back to D, plus load-use and multiplier handshake stalls.
    always_comb begin
        stall_W = stall_W_ext;
        stall_M = stall_M_ext | stall_W;
        stall_X = stall_X_ext | stall_M | (x_q.val & x_q.is_mul & ~imul_resp_val);
        luse    = x_q.val & x_q.is_load & x_q.wen & (x_q.rd != 5'd0)
                & ((rs1_en_D & (rs1_D == x_q.rd)) | (rs2_en_D & (rs2_D == x_q.rd)));
        stall_D_nm    = val_D & (stall_X | luse);
        stall_D       = stall_D_nm | (val_D & is_mul_D & ~squash_D & ~imul_req_rdy);
        imul_req_val  = val_D & is_mul_D & ~squash_D & ~stall_D_nm;
        imul_resp_rdy = x_q.val & x_q.is_mul & ~stall_X_ext & ~stall_M;
    end

    // Bypass selects, youngest producer first; a load in X has no data yet so it is skipped.
    always_comb begin
        op1_byp_sel_D = BYP1_RF;
        op2_byp_sel_D = BYP2_RF;
        if (rs1_en_D && rs1_D != 5'd0) begin
            if (byp_match(x_q, rs1_D) && !x_q.is_load) op1_byp_sel_D = BYP1_X;
            else if (byp_match(m_q, rs1_D))             op1_byp_sel_D = BYP1_M;
            else if (byp_match(w_q, rs1_D))             op1_byp_sel_D = BYP1_W;
        end
        if (rs2_en_D && rs2_D != 5'd0) begin
            if (byp_match(x_q, rs2_D) && !x_q.is_load) op2_byp_sel_D = BYP2_X;
            else if (byp_match(m_q, rs2_D))             op2_byp_sel_D = BYP2_M;
            else if (byp_match(w_q, rs2_D))             op2_byp_sel_D = BYP2_W;
        end
    end

    // Entry offered to X by the D stage; squashed or stalled instructions become bubbles.
    always_comb begin
        x_d.val     = 1'b1;
        x_d.wen     = rf_wen_D;
        x_d.rd      = rd_D;
        x_d.is_load = is_load_D;
        x_d.is_mul  = is_mul_D;
        x_bubble    = ~(val_D & ~stall_D & ~squash_D);
    end

    lab2_proc_hazard_stage_reg u_stage_x (
        .clk    (clk),
        .reset  (reset),
        .hold   (stall_X),
        .bubble (x_bubble),
        .d      (x_d),
        .q      (x_q)
    );

    lab2_proc_hazard_stage_reg u_stage_m (
        .clk    (clk),
        .reset  (reset),
        .hold   (stall_M),
        .bubble (stall_X),
        .d      (x_q),
        .q      (m_q)
    );

    lab2_proc_hazard_stage_reg u_stage_w (
        .clk    (clk),
        .reset  (reset),
        .hold   (stall_W),
        .bubble (stall_M),
        .d      (m_q),
        .q      (w_q)
    );

    // Statistics: count D-stall cycles while enabled; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else if (stats_en && stall_D) begin
            stall_cycles_q <= stall_cycles_q + p_cnt_nbits'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign val_X        = x_q.val;
    assign val_M        = m_q.val;
    assign val_W        = w_q.val;

endmodule

// File: tb/tb_lab2_proc_hazard_ctrl.sv
// Directed and randomized checks of the hazard controller against a stage-array reference model.
module tb_lab2_proc_hazard_ctrl;

    // Narrow counter so wrap-around is reachable in simulation.
    localparam int unsigned CNT_W = 6;

    logic clk = 1'b0;
    logic reset;
    logic val_D, squash_D, rs1_en_D, rs2_en_D, rf_wen_D, is_load_D, is_mul_D;
    logic [4:0] rs1_D, rs2_D, rd_D;
    logic stall_X_ext, stall_M_ext, stall_W_ext, imul_req_rdy, imul_resp_val, stats_en;
    logic [1:0] op1_byp_sel_D, op2_byp_sel_D;
    logic stall_D, stall_X, stall_M, stall_W, imul_req_val, imul_resp_rdy;
    logic val_X, val_M, val_W;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = X, 1 = M, 2 = W
    bit       mv[3], mw[3], mld[3], mmul[3];
    bit [4:0] mrd[3];
    bit [CNT_W-1:0] mcnt;
    bit [1:0] e_sel1, e_sel2;
    bit       e_sD, e_sX, e_sM, e_sW, e_req, e_rsp;

    always #5 clk = ~clk;

    lab2_proc_hazard_ctrl #(.p_cnt_nbits(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .val_D         (val_D),
        .squash_D      (squash_D),
        .rs1_en_D      (rs1_en_D),
        .rs2_en_D      (rs2_en_D),
        .rs1_D         (rs1_D),
        .rs2_D         (rs2_D),
        .rf_wen_D      (rf_wen_D),
        .rd_D          (rd_D),
        .is_load_D     (is_load_D),
        .is_mul_D      (is_mul_D),
        .stall_X_ext   (stall_X_ext),
        .stall_M_ext   (stall_M_ext),
        .stall_W_ext   (stall_W_ext),
        .imul_req_rdy  (imul_req_rdy),
        .imul_resp_val (imul_resp_val),
        .stats_en      (stats_en),
        .op1_byp_sel_D (op1_byp_sel_D),
        .op2_byp_sel_D (op2_byp_sel_D),
        .stall_D       (stall_D),
        .stall_X       (stall_X),
        .stall_M       (stall_M),
        .stall_W       (stall_W),
        .imul_req_val  (imul_req_val),
        .imul_resp_rdy (imul_resp_rdy),
        .val_X         (val_X),
        .val_M         (val_M),
        .val_W         (val_W),
        .stall_cycles  (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        val_D = 0; squash_D = 0; rs1_en_D = 0; rs2_en_D = 0; rf_wen_D = 0;
        is_load_D = 0; is_mul_D = 0; rs1_D = 0; rs2_D = 0; rd_D = 0;
        stall_X_ext = 0; stall_M_ext = 0; stall_W_ext = 0;
        imul_req_rdy = 1; imul_resp_val = 0; stats_en = 1;
    endtask

    task automatic set_d(input bit wen, input bit [4:0] rd, input bit en1, input bit [4:0] r1,
                         input bit en2, input bit [4:0] r2, input bit ld, input bit mul);
        val_D = 1; rf_wen_D = wen; rd_D = rd; rs1_en_D = en1; rs1_D = r1;
        rs2_en_D = en2; rs2_D = r2; is_load_D = ld; is_mul_D = mul; squash_D = 0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            mv[s] = 0; mw[s] = 0; mld[s] = 0; mmul[s] = 0; mrd[s] = 0;
        end
        mcnt = '0;
    endtask

    // Youngest stage that writes rs, or -1 for the register file.
    function automatic int producer(input bit en, input bit [4:0] rs);
        if (!en || rs == 0) return -1;
        for (int s = 0; s < 3; s++) begin
            if (s == 0 && mld[0]) continue;
            if (mv[s] && mw[s] && mrd[s] == rs) return s;
        end
        return -1;
    endfunction

    task automatic model_eval();
        bit luse, nm;
        int p1, p2;
        e_sW = stall_W_ext;
        e_sM = stall_M_ext | e_sW;
        e_sX = stall_X_ext | e_sM | (mv[0] & mmul[0] & !imul_resp_val);
        luse = mv[0] && mld[0] && mw[0] && mrd[0] != 0 &&
               ((rs1_en_D && rs1_D == mrd[0]) || (rs2_en_D && rs2_D == mrd[0]));
        nm    = val_D && (e_sX || luse);
        e_sD  = nm || (val_D && is_mul_D && !squash_D && !imul_req_rdy);
        e_req = val_D && is_mul_D && !squash_D && !nm;
        e_rsp = mv[0] && mmul[0] && !stall_X_ext && !e_sM;
        p1 = producer(rs1_en_D, rs1_D);
        p2 = producer(rs2_en_D, rs2_D);
        e_sel1 = (p1 < 0) ? 2'd0 : 2'(p1 + 1);
        e_sel2 = (p2 < 0) ? 2'd3 : 2'(p2);
    endtask

    task automatic model_advance();
        if (!e_sW) begin
            mv[2] = e_sM ? 0 : mv[1];
            mw[2] = mw[1]; mrd[2] = mrd[1]; mld[2] = mld[1]; mmul[2] = mmul[1];
        end
        if (!e_sM) begin
            mv[1] = e_sX ? 0 : mv[0];
            mw[1] = mw[0]; mrd[1] = mrd[0]; mld[1] = mld[0]; mmul[1] = mmul[0];
        end
        if (!e_sX) begin
            mv[0] = val_D && !e_sD && !squash_D;
            mw[0] = rf_wen_D; mrd[0] = rd_D; mld[0] = is_load_D; mmul[0] = is_mul_D;
        end
        if (stats_en && e_sD) mcnt = mcnt + 1'b1;
    endtask

    // Compare every output with the model at the falling edge.
    task automatic check_cycle(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".op1_sel"}, 32'(op1_byp_sel_D), 32'(e_sel1));
        chk({tag, ".op2_sel"}, 32'(op2_byp_sel_D), 32'(e_sel2));
        chk({tag, ".stall_D"}, 32'(stall_D), 32'(e_sD));
        chk({tag, ".stall_X"}, 32'(stall_X), 32'(e_sX));
        chk({tag, ".stall_M"}, 32'(stall_M), 32'(e_sM));
        chk({tag, ".stall_W"}, 32'(stall_W), 32'(e_sW));
        chk({tag, ".req_val"}, 32'(imul_req_val), 32'(e_req));
        chk({tag, ".resp_rdy"}, 32'(imul_resp_rdy), 32'(e_rsp));
        chk({tag, ".val_X"}, 32'(val_X), 32'(mv[0]));
        chk({tag, ".val_M"}, 32'(val_M), 32'(mv[1]));
        chk({tag, ".val_W"}, 32'(val_W), 32'(mv[2]));
        chk({tag, ".cnt"}, 32'(stall_cycles), 32'(mcnt));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) model_clear();
        else model_advance();
        #1;
    endtask

    task automatic step(input string tag);
        check_cycle(tag);
        advance();
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        model_clear();
        e_sD = 0; e_sX = 0; e_sM = 0; e_sW = 0;

        // Reset state
        check_cycle("reset");
        chk("reset.op1_rf", 32'(op1_byp_sel_D), 32'd0);
        chk("reset.op2_rf", 32'(op2_byp_sel_D), 32'd3);
        advance();
        reset = 1;
        step("idle");

        // 1: addi x1; add x2,x1,x1 -> bypass from X
        set_d(1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0);
        step("t1.addi");
        set_d(1, 5'd2, 1, 5'd1, 1, 5'd1, 0, 0);
        check_cycle("t1.add");
        chk("t1.op1_X", 32'(op1_byp_sel_D), 32'd1);
        chk("t1.op2_X", 32'(op2_byp_sel_D), 32'd0);
        chk("t1.no_stall", 32'(stall_D), 32'd0);
        advance();

        // 2: lw x3; add x4,x3,x0 -> one load-use stall, then bypass from M
        set_d(1, 5'd3, 1, 5'd0, 0, 5'd0, 1, 0);
        step("t2.lw");
        set_d(1, 5'd4, 1, 5'd3, 1, 5'd0, 0, 0);
        check_cycle("t2.luse");
        chk("t2.stall", 32'(stall_D), 32'd1);
        advance();
        check_cycle("t2.after");
        chk("t2.no_stall", 32'(stall_D), 32'd0);
        chk("t2.op1_M", 32'(op1_byp_sel_D), 32'd2);
        advance();

        // 3: mul x5 with response 4 cycles late, dependent add behind
        set_d(1, 5'd5, 1, 5'd1, 1, 5'd2, 0, 1);
        check_cycle("t3.mul");
        chk("t3.req_val", 32'(imul_req_val), 32'd1);
        advance();
        set_d(1, 5'd6, 1, 5'd5, 0, 5'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check_cycle("t3.wait");
            chk("t3.stall_X", 32'(stall_X), 32'd1);
            chk("t3.stall_D", 32'(stall_D), 32'd1);
            advance();
        end
        imul_resp_val = 1;
        check_cycle("t3.resp");
        chk("t3.released", 32'(stall_D), 32'd0);
        chk("t3.op1_X", 32'(op1_byp_sel_D), 32'd1);
        chk("t3.resp_rdy", 32'(imul_resp_rdy), 32'd1);
        advance();
        imul_resp_val = 0;

        // 4: x6 in both X and W -> X wins; then x0 writer in X with rs1=x0 -> rf
        set_d(1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 0);
        step("t4.w6a");
        set_d(1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 0);
        step("t4.w7");
        set_d(1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 0);
        step("t4.w6b");
        set_d(1, 5'd8, 1, 5'd6, 1, 5'd6, 0, 0);
        check_cycle("t4.rd6");
        chk("t4.op1_X", 32'(op1_byp_sel_D), 32'd1);
        chk("t4.op2_X", 32'(op2_byp_sel_D), 32'd0);
        advance();
        set_d(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        step("t4.wx0");
        set_d(1, 5'd9, 1, 5'd0, 1, 5'd0, 0, 0);
        check_cycle("t4.rdx0");
        chk("t4.op1_rf", 32'(op1_byp_sel_D), 32'd0);
        chk("t4.op2_rf", 32'(op2_byp_sel_D), 32'd3);
        advance();

        // 5: squashed mul in D never issues, X gets a bubble
        set_d(1, 5'd10, 0, 5'd0, 0, 5'd0, 0, 1);
        squash_D = 1;
        imul_req_rdy = 1;
        check_cycle("t5.sq");
        chk("t5.no_req", 32'(imul_req_val), 32'd0);
        advance();
        clear_inputs();
        check_cycle("t5.bub");
        chk("t5.val_X", 32'(val_X), 32'd0);
        advance();

        // 6: fill pipeline, then drop reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            set_d(1, 5'(11 + i), 0, 5'd0, 0, 5'd0, 0, 0);
            step("t6.fill");
        end
        clear_inputs();
        check_cycle("t6.full");
        chk("t6.val_W", 32'(val_W), 32'd1);
        advance();
        #1 reset = 0;
        #1;
        chk("t6.rst_val_X", 32'(val_X), 32'd0);
        chk("t6.rst_val_M", 32'(val_M), 32'd0);
        chk("t6.rst_val_W", 32'(val_W), 32'd0);
        chk("t6.rst_cnt", 32'(stall_cycles), 32'd0);
        model_clear();
        step("t6.inreset");
        reset = 1;
        step("t6.release");

        // Counter wrap: 2^CNT_W - 1 stalls, then one more
        set_d(1, 5'd1, 0, 5'd0, 0, 5'd0, 0, 0);
        stall_W_ext = 1;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) step("wrap.fill");
        check_cycle("wrap.max");
        chk("wrap.max_val", 32'(stall_cycles), 32'((1 << CNT_W) - 1));
        advance();
        check_cycle("wrap.zero");
        chk("wrap.zero_val", 32'(stall_cycles), 32'd0);
        advance();
        clear_inputs();

        // Randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            val_D         = ($urandom_range(0, 3) != 0);
            squash_D      = ($urandom_range(0, 7) == 0);
            rs1_en_D      = $urandom_range(0, 1);
            rs2_en_D      = $urandom_range(0, 1);
            rs1_D         = 5'($urandom_range(0, 3));
            rs2_D         = 5'($urandom_range(0, 3));
            rf_wen_D      = ($urandom_range(0, 3) != 0);
            rd_D          = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       begin is_load_D = 1; is_mul_D = 0; end
                1:       begin is_load_D = 0; is_mul_D = 1; end
                default: begin is_load_D = 0; is_mul_D = 0; end
            endcase
            stall_X_ext   = ($urandom_range(0, 9) == 0);
            stall_M_ext   = ($urandom_range(0, 9) == 0);
            stall_W_ext   = ($urandom_range(0, 9) == 0);
            imul_req_rdy  = ($urandom_range(0, 3) != 0);
            imul_resp_val = ($urandom_range(0, 2) == 0);
            stats_en      = ($urandom_range(0, 4) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
